// File: rtl/game_timer_pkg.sv
// Shared types and helpers for the BlackJack game timer bank.
package game_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } timer_state_t;

  // Terminal count that gives a 2 s interval with the default 2 kHz timebase.
  localparam int LIMIT_2S = 4000;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/game_timer_bank_channel.sv
// One start/stop timer channel: limit latch, tick counter, done pulse and sticky expired flag.
module timer_channel
  import game_timer_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk_50M,
  input  logic             i_RstCounter,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             expired,
  output timer_state_t     state
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  timer_state_t     state_n;
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] lim_q;
  logic [WIDTH-1:0] lim_n;
  logic             done_n;
  logic             expired_n;

  always_ff @(posedge clk_50M or posedge i_RstCounter) begin
    if (i_RstCounter) begin
      state   <= ST_IDLE;
      count   <= '0;
      lim_q   <= '0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      lim_q   <= lim_n;
      done    <= done_n;
      expired <= expired_n;
    end
  end

  // Start wins over stop and over a coincident tick; a zero limit expires at once.
  always_comb begin
    state_n   = state;
    count_n   = count;
    lim_n     = lim_q;
    done_n    = 1'b0;
    expired_n = expired;
    if (start) begin
      count_n = '0;
      lim_n   = limit;
      if (limit == '0) begin
        state_n   = ST_EXPIRED;
        done_n    = 1'b1;
        expired_n = 1'b1;
      end else begin
        state_n   = ST_RUN;
        expired_n = 1'b0;
      end
    end else begin
      case (state)
        ST_RUN: begin
          if (stop) begin
            state_n = ST_IDLE;
          end else if (tick) begin
            count_n = count + ONE;
            if (count_n == lim_q) begin
              state_n   = ST_EXPIRED;
              done_n    = 1'b1;
              expired_n = 1'b1;
            end
          end
        end
        ST_EXPIRED: begin
          if (stop) begin
            state_n   = ST_IDLE;
            expired_n = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/game_timer_bank.sv
// Multi-channel game timer with a shared tick prescaler and a button-driven seed counter.
module game_timer_bank
  import game_timer_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int TICK_HZ    = 2000,
  parameter int WIDTH      = 12,
  parameter int CHANNELS   = 2,
  parameter int SEED_WIDTH = 12
) (
  input  logic                      clk_50M,
  input  logic                      i_RstCounter,
  input  logic                      i_Reset,
  input  logic [CHANNELS-1:0]       i_Start,
  input  logic [CHANNELS-1:0]       i_Stop,
  input  logic [CHANNELS*WIDTH-1:0] i_Limit,
  output logic                      o_Tick,
  output logic [SEED_WIDTH-1:0]     o_Seed,
  output logic [CHANNELS*WIDTH-1:0] o_Count,
  output logic [CHANNELS-1:0]       o_Busy,
  output logic [CHANNELS-1:0]       o_Done,
  output logic [CHANNELS-1:0]       o_Expired
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int PW  = clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [SEED_WIDTH-1:0] SEED_ONE = SEED_WIDTH'(1);

  logic [PW-1:0] presc;

  // Tick is registered, so it lands one cycle after the prescaler hits its last value.
  always_ff @(posedge clk_50M or posedge i_RstCounter) begin
    if (i_RstCounter) begin
      presc  <= '0;
      o_Tick <= 1'b0;
    end else begin
      o_Tick <= (presc == PRESC_LAST);
      presc  <= (presc == PRESC_LAST) ? '0 : presc + PRESC_ONE;
    end
  end

  always_ff @(posedge clk_50M or posedge i_RstCounter) begin
    if (i_RstCounter) begin
      o_Seed <= '0;
    end else if (i_Reset && (o_Busy == '0)) begin
      o_Seed <= o_Seed + SEED_ONE;
    end
  end

  timer_state_t ch_state [CHANNELS];

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    timer_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk_50M     (clk_50M),
      .i_RstCounter(i_RstCounter),
      .tick        (o_Tick),
      .start       (i_Start[k]),
      .stop        (i_Stop[k]),
      .limit       (i_Limit[k*WIDTH +: WIDTH]),
      .count       (o_Count[k*WIDTH +: WIDTH]),
      .done        (o_Done[k]),
      .expired     (o_Expired[k]),
      .state       (ch_state[k])
    );
    assign o_Busy[k] = (ch_state[k] == ST_RUN);
  end

endmodule

// File: tb/tb_game_timer_bank.sv
// Bench for game_timer_bank: directed scenarios with literal expectations plus a random phase against a reference model.
module tb_game_timer_bank;

  localparam int CLK_HZ  = 100;
  localparam int TICK_HZ = 10;
  localparam int DIV     = 10;
  localparam int W       = 4;
  localparam int CH      = 2;
  localparam int SW      = 4;

  logic            clk_50M = 1'b0;
  logic            i_RstCounter = 1'b1;
  logic            i_Reset = 1'b0;
  logic [CH-1:0]   i_Start = '0;
  logic [CH-1:0]   i_Stop = '0;
  logic [CH*W-1:0] i_Limit = '0;
  logic            o_Tick;
  logic [SW-1:0]   o_Seed;
  logic [CH*W-1:0] o_Count;
  logic [CH-1:0]   o_Busy;
  logic [CH-1:0]   o_Done;
  logic [CH-1:0]   o_Expired;

  game_timer_bank #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .WIDTH(W), .CHANNELS(CH), .SEED_WIDTH(SW)
  ) dut (
    .clk_50M(clk_50M), .i_RstCounter(i_RstCounter), .i_Reset(i_Reset),
    .i_Start(i_Start), .i_Stop(i_Stop), .i_Limit(i_Limit),
    .o_Tick(o_Tick), .o_Seed(o_Seed), .o_Count(o_Count),
    .o_Busy(o_Busy), .o_Done(o_Done), .o_Expired(o_Expired)
  );

  // clock / reset
  always #5 clk_50M = ~clk_50M;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: channel is running, expired, or neither (idle).
  int m_cyc = 0;
  bit m_tick = 0;
  int m_seed = 0;
  int m_cnt [CH];
  int m_lim [CH];
  bit m_run [CH];
  bit m_exp [CH];
  bit m_done[CH];

  task automatic model_reset();
    m_cyc = 0; m_tick = 0; m_seed = 0;
    for (int k = 0; k < CH; k++) begin
      m_cnt[k] = 0; m_lim[k] = 0; m_run[k] = 0; m_exp[k] = 0; m_done[k] = 0;
    end
  endtask

  task automatic model_step();
    bit old_tick;
    bit any_run;
    old_tick = m_tick;
    any_run = 0;
    for (int k = 0; k < CH; k++) any_run |= m_run[k];
    m_cyc++;
    m_tick = (m_cyc % DIV == 0);
    if (i_Reset && !any_run) m_seed = (m_seed + 1) % (1 << SW);
    for (int k = 0; k < CH; k++) begin
      m_done[k] = 0;
      if (i_Start[k]) begin
        m_cnt[k] = 0;
        m_lim[k] = int'(i_Limit[k*W +: W]);
        if (m_lim[k] == 0) begin
          m_run[k] = 0; m_exp[k] = 1; m_done[k] = 1;
        end else begin
          m_run[k] = 1; m_exp[k] = 0;
        end
      end else if (m_run[k]) begin
        if (i_Stop[k]) m_run[k] = 0;
        else if (old_tick) begin
          m_cnt[k]++;
          if (m_cnt[k] == m_lim[k]) begin
            m_run[k] = 0; m_exp[k] = 1; m_done[k] = 1;
          end
        end
      end else if (m_exp[k] && i_Stop[k]) begin
        m_exp[k] = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_50M or posedge i_RstCounter);
      if (i_RstCounter) model_reset();
      else model_step();
    end
  end

  // scoreboard: compare every cycle, 2 time units after the active edge
  initial begin
    forever begin
      @(posedge clk_50M);
      #2;
      check("tick", int'(o_Tick), int'(m_tick));
      check("seed", int'(o_Seed), m_seed);
      for (int k = 0; k < CH; k++) begin
        check($sformatf("count%0d", k), int'(o_Count[k*W +: W]), m_cnt[k]);
        check($sformatf("busy%0d", k), int'(o_Busy[k]), int'(m_run[k]));
        check($sformatf("done%0d", k), int'(o_Done[k]), int'(m_done[k]));
        check($sformatf("expired%0d", k), int'(o_Expired[k]), int'(m_exp[k]));
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk_50M);
    #2;
  endtask

  function automatic int cnt(input int k);
    return int'(o_Count[k*W +: W]);
  endfunction

  task automatic strobe_start(input int k, input int lim, input bit with_stop);
    i_Limit[k*W +: W] = W'(lim);
    i_Start[k] = 1'b1;
    i_Stop[k] = with_stop;
    step();
    i_Start[k] = 1'b0;
    i_Stop[k] = 1'b0;
  endtask

  task automatic strobe_stop(input logic [CH-1:0] mask);
    i_Stop = mask;
    step();
    i_Stop = '0;
  endtask

  task automatic wait_count(input int k, input int val, input string name);
    int n;
    n = 0;
    while (cnt(k) != val && n < 200) begin
      step();
      n++;
    end
    check(name, int'(n < 200), 1);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!o_Tick && n < 50);
  endtask

  int n;

  initial begin
    // reset state
    repeat (3) step();
    check("rst_count", int'(o_Count), 0);
    check("rst_seed", int'(o_Seed), 0);
    check("rst_flags", int'({o_Busy, o_Done, o_Expired, o_Tick}), 0);
    i_RstCounter = 1'b0;
    wait_tick(n);
    check("first_tick_latency", n, 10);
    wait_tick(n);
    check("tick_period", n, 10);

    // ch0 runs to limit 3 and holds
    strobe_start(0, 3, 1'b0);
    check("ch0_busy_after_start", int'(o_Busy[0]), 1);
    n = 0;
    while (!o_Done[0] && n < 60) begin
      step();
      n++;
    end
    check("ch0_done_seen", int'(o_Done[0]), 1);
    check("ch0_count_at_done", cnt(0), 3);
    step();
    check("ch0_done_one_cycle", int'(o_Done[0]), 0);
    check("ch0_expired_sticky", int'(o_Expired[0]), 1);
    repeat (60) step();
    check("ch0_count_holds", cnt(0), 3);
    check("ch0_still_expired", int'(o_Expired[0]), 1);

    // ch1 stopped mid-run, then restarted with a zero limit
    strobe_start(1, 5, 1'b0);
    wait_count(1, 2, "ch1_reach2_timeout");
    strobe_stop(2'b10);
    check("ch1_stop_busy", int'(o_Busy[1]), 0);
    check("ch1_stop_count", cnt(1), 2);
    repeat (30) step();
    check("ch1_count_held", cnt(1), 2);
    check("ch1_no_expiry", int'(o_Expired[1]), 0);
    strobe_start(1, 0, 1'b0);
    check("ch1_zero_done", int'(o_Done[1]), 1);
    check("ch1_zero_count", cnt(1), 0);
    step();
    check("ch1_zero_done_end", int'(o_Done[1]), 0);

    // start + stop coincident with a tick: restart wins, tick not counted
    strobe_start(0, 9, 1'b0);
    wait_count(0, 2, "ch0_reach2_timeout");
    wait_tick(n);
    check("tick_sync", int'(o_Tick), 1);
    strobe_start(0, 9, 1'b1);
    check("restart_count", cnt(0), 0);
    check("restart_busy", int'(o_Busy[0]), 1);

    // seed counting with everything idle, wrap, then hold while busy
    strobe_stop(2'b11);
    i_Reset = 1'b1;
    repeat (12) step();
    check("seed_12", int'(o_Seed), 12);
    repeat (8) step();
    check("seed_wrap_20", int'(o_Seed), 4);
    i_Reset = 1'b0;
    strobe_start(0, 15, 1'b0);
    i_Reset = 1'b1;
    repeat (10) step();
    check("seed_hold_busy", int'(o_Seed), 4);
    i_Reset = 1'b0;

    // asynchronous reset mid-run
    wait_count(0, 2, "ch0_reach2b_timeout");
    #1 i_RstCounter = 1'b1;
    #1;
    check("async_count", int'(o_Count), 0);
    check("async_seed", int'(o_Seed), 0);
    check("async_flags", int'({o_Busy, o_Done, o_Expired, o_Tick}), 0);
    repeat (2) step();
    i_RstCounter = 1'b0;
    wait_tick(n);
    check("post_reset_tick_latency", n, 10);
    check("post_reset_idle", int'({o_Busy, o_Expired}), 0);

    // random phase
    for (int c = 0; c < 900; c++) begin
      for (int k = 0; k < CH; k++) begin
        if ($urandom_range(0, 39) == 0) i_Start[k] = 1'b1;
        if ($urandom_range(0, 29) == 0) i_Stop[k] = 1'b1;
        if ($urandom_range(0, 9) == 0) i_Limit[k*W +: W] = W'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 19) == 0) i_Reset = ~i_Reset;
      if (c == 450) begin
        #1 i_RstCounter = 1'b1;
        step();
        i_RstCounter = 1'b0;
      end else begin
        step();
      end
      i_Start = '0;
      i_Stop = '0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
